// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morse_pkg
// Description : Shared constants for the Morse sequence builder.
//               Symbol codes stored in the slot register. Event codes
//               reported on Signals.
// Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

    // Symbol codes. 2'b10 is reserved and never written.
    localparam logic [1:0] SYM_DOT   = 2'b00;
    localparam logic [1:0] SYM_DASH  = 2'b01;
    localparam logic [1:0] SYM_EMPTY = 2'b11;

    // Event codes. The MSB is set for every real event.
    localparam logic [2:0] EV_NONE   = 3'b000;
    localparam logic [2:0] EV_DOT    = 3'b100;
    localparam logic [2:0] EV_DASH   = 3'b101;
    localparam logic [2:0] EV_SPACE  = 3'b110;
    localparam logic [2:0] EV_ENDSEQ = 3'b111;

endpackage : morse_pkg
`default_nettype wire

// File: rtl/morse_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_event_encoder
// Description : Detects rising edges on the four key inputs and reduces them
//               to one event code, with priority EndSeq > Space > Dash > Dot.
//               The event is available combinationally on o_event so the
//               consumer can act on the same clock edge that registers
//               o_signals.
// Ports       : i_clk, i_rst_n (async, active low)
//               i_dot, i_dash, i_space, i_endseq  - key levels
//               o_event   - current-cycle event code (combinational)
//               o_signals - registered event code
// Revision    : 1.0 - initial release
// ============================================================================
module morse_event_encoder
    import morse_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_dot,
    input  logic       i_dash,
    input  logic       i_space,
    input  logic       i_endseq,
    output logic [2:0] o_event,
    output logic [2:0] o_signals
);

    logic [3:0] r_hist;
    logic [3:0] w_keys;
    logic [3:0] w_rise;
    logic [2:0] w_event;
    logic [2:0] r_signals;

    // Bit order {endseq, space, dash, dot}
    assign w_keys = {i_endseq, i_space, i_dash, i_dot};
    assign w_rise = w_keys & ~r_hist;

    always_comb begin
        w_event = EV_NONE;
        if (w_rise[3])      w_event = EV_ENDSEQ;
        else if (w_rise[2]) w_event = EV_SPACE;
        else if (w_rise[1]) w_event = EV_DASH;
        else if (w_rise[0]) w_event = EV_DOT;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist    <= 4'b0000;
            r_signals <= EV_NONE;
        end else begin
            r_hist    <= w_keys;
            r_signals <= w_event;
        end
    end

    assign o_event   = w_event;
    assign o_signals = r_signals;

endmodule : morse_event_encoder
`default_nettype wire

// File: rtl/morse_sequence_builder.sv
`default_nettype none
// ============================================================================
// Module      : morse_sequence_builder
// Description : Accumulates Dot/Dash key events into MAX_SYMBOLS two-bit
//               slots (slot 0 in the MSBs) and latches how the sequence was
//               terminated (Space or EndSeq).
// Ports       : Clk, Reset_n (async, active low), Dot, Dash, Space, EndSeq,
//               Clear (sync), Signals, EncSeq, Space_EndSeqbar, SeqValid,
//               Overflow, and SymCount when MORSE_SYMCOUNT_EN is defined.
// Options     : MORSE_SYMCOUNT_EN - exposes the internal symbol count.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_sequence_builder
    import morse_pkg::*;
#(
    parameter int MAX_SYMBOLS = 5
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         Dot,
    input  logic                         Dash,
    input  logic                         Space,
    input  logic                         EndSeq,
    input  logic                         Clear,
    output logic [2:0]                   Signals,
    output logic [2*MAX_SYMBOLS-1:0]     EncSeq,
    output logic                         Space_EndSeqbar,
    output logic                         SeqValid,
    output logic                         Overflow
`ifdef MORSE_SYMCOUNT_EN
    ,
    output logic [$clog2(MAX_SYMBOLS+1)-1:0] SymCount
`endif
);

    localparam int CW = $clog2(MAX_SYMBOLS + 1);

    logic [2:0]               w_event;
    logic [2*MAX_SYMBOLS-1:0] r_enc;
    logic [2*MAX_SYMBOLS-1:0] w_enc_next;
    logic [CW-1:0]            r_count;
    logic                     r_valid;
    logic                     r_sebar;
    logic                     r_ovf;
    logic                     w_is_sym;
    logic                     w_full;
    logic [1:0]               w_sym;

    morse_event_encoder u_enc (
        .i_clk     (Clk),
        .i_rst_n   (Reset_n),
        .i_dot     (Dot),
        .i_dash    (Dash),
        .i_space   (Space),
        .i_endseq  (EndSeq),
        .o_event   (w_event),
        .o_signals (Signals)
    );

    assign w_is_sym = (w_event == EV_DOT) || (w_event == EV_DASH);
    assign w_sym    = (w_event == EV_DASH) ? SYM_DASH : SYM_DOT;
    assign w_full   = (r_count == CW'(MAX_SYMBOLS));

    // Slot register with the current symbol dropped into slot[r_count].
    always_comb begin
        w_enc_next = r_enc;
        for (int k = 0; k < MAX_SYMBOLS; k++) begin
            if (r_count == CW'(k)) begin
                w_enc_next[2*(MAX_SYMBOLS-k)-1 -: 2] = w_sym;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_enc   <= '1;
            r_count <= '0;
            r_valid <= 1'b0;
            r_sebar <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (Clear) begin
            // Terminator kind is intentionally retained across Clear.
            r_enc   <= '1;
            r_count <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (!r_valid) begin
            if (w_is_sym) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_enc   <= w_enc_next;
                    r_count <= r_count + CW'(1);
                end
            end else if (w_event == EV_SPACE) begin
                r_valid <= 1'b1;
                r_sebar <= 1'b1;
            end else if (w_event == EV_ENDSEQ) begin
                r_valid <= 1'b1;
                r_sebar <= 1'b0;
            end
        end
    end

    assign EncSeq          = r_enc;
    assign SeqValid        = r_valid;
    assign Space_EndSeqbar = r_sebar;
    assign Overflow        = r_ovf;
`ifdef MORSE_SYMCOUNT_EN
    assign SymCount        = r_count;
`endif

endmodule : morse_sequence_builder
`default_nettype wire

// File: tb/tb_morse_sequence_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_sequence_builder
// Description : Self-checking bench for morse_sequence_builder: a vector
//               table, hand-written corner sequences and a randomized run
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_sequence_builder;

    localparam int MAXS = 5;
    localparam int EW   = 2 * MAXS;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Dot = 1'b0, Dash = 1'b0, Space = 1'b0, EndSeq = 1'b0;
    logic          Clear = 1'b0;
    logic [2:0]    Signals;
    logic [EW-1:0] EncSeq;
    logic          Space_EndSeqbar, SeqValid, Overflow;
`ifdef MORSE_SYMCOUNT_EN
    logic [$clog2(MAXS+1)-1:0] SymCount;
`endif

    morse_sequence_builder #(.MAX_SYMBOLS(MAXS)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Dot             (Dot),
        .Dash            (Dash),
        .Space           (Space),
        .EndSeq          (EndSeq),
        .Clear           (Clear),
        .Signals         (Signals),
        .EncSeq          (EncSeq),
        .Space_EndSeqbar (Space_EndSeqbar),
        .SeqValid        (SeqValid),
        .Overflow        (Overflow)
`ifdef MORSE_SYMCOUNT_EN
        ,
        .SymCount        (SymCount)
`endif
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Key bit order {EndSeq, Space, Dash, Dot}
    localparam logic [3:0] K0 = 4'b0000, KD = 4'b0001, KA = 4'b0010,
                           KS = 4'b0100, KE = 4'b1000;

    // ---------------- reference model ----------------
    logic [3:0] m_prev;
    logic [1:0] m_q[$];
    logic       m_valid, m_sebar, m_ovf;
    logic [2:0] m_sig;

    task automatic m_reset();
        m_prev = 4'b0; m_q.delete();
        m_valid = 1'b0; m_sebar = 1'b0; m_ovf = 1'b0; m_sig = 3'b000;
    endtask

    task automatic m_step(input logic [3:0] keys, input logic clr);
        logic [3:0] rise;
        rise   = keys & ~m_prev;
        m_prev = keys;
        if (rise[3])      m_sig = 3'b111;
        else if (rise[2]) m_sig = 3'b110;
        else if (rise[1]) m_sig = 3'b101;
        else if (rise[0]) m_sig = 3'b100;
        else              m_sig = 3'b000;
        if (clr) begin
            m_q.delete(); m_valid = 1'b0; m_ovf = 1'b0;
        end else if (!m_valid) begin
            if (m_sig == 3'b100 || m_sig == 3'b101) begin
                if (m_q.size() < MAXS) m_q.push_back(m_sig == 3'b101 ? 2'b01 : 2'b00);
                else                   m_ovf = 1'b1;
            end else if (m_sig == 3'b110 || m_sig == 3'b111) begin
                m_valid = 1'b1;
                m_sebar = (m_sig == 3'b110);
            end
        end
    endtask

    function automatic logic [EW-1:0] m_enc();
        logic [EW-1:0] v;
        v = '0;
        for (int i = 0; i < MAXS; i++)
            v = {v[EW-3:0], (i < m_q.size()) ? m_q[i] : 2'b11};
        return v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] s, input logic [EW-1:0] e,
                           input logic v, input logic se, input logic ov);
        chk({tag, ".Signals"}, 32'(Signals), 32'(s));
        chk({tag, ".EncSeq"}, 32'(EncSeq), 32'(e));
        chk({tag, ".SeqValid"}, 32'(SeqValid), 32'(v));
        chk({tag, ".Space_EndSeqbar"}, 32'(Space_EndSeqbar), 32'(se));
        chk({tag, ".Overflow"}, 32'(Overflow), 32'(ov));
    endtask

    // One clock: drive at negedge, sample 1 time unit after posedge.
    task automatic cyc(input logic [3:0] keys, input logic clr);
        @(negedge Clk);
        {EndSeq, Space, Dash, Dot} = keys;
        Clear = clr;
        @(posedge Clk);
        #1;
        m_step(keys, clr);
    endtask

    task automatic cyc_m(input string tag, input logic [3:0] keys, input logic clr);
        cyc(keys, clr);
        chk_all(tag, m_sig, m_enc(), m_valid, m_sebar, m_ovf);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]    keys;
        logic          clr;
        logic [2:0]    sig;
        logic [EW-1:0] enc;
        logic          v;
        logic          se;
        logic          ov;
    } vec_t;

    vec_t tbl[26];

    initial begin
        tbl[0]  = '{K0, 1'b1, 3'b000, 10'h3FF, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{KD, 1'b0, 3'b100, 10'h0FF, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{K0, 1'b0, 3'b000, 10'h0FF, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{KA, 1'b0, 3'b101, 10'h07F, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{K0, 1'b0, 3'b000, 10'h07F, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{KD, 1'b0, 3'b100, 10'h04F, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{K0, 1'b0, 3'b000, 10'h04F, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{KD, 1'b0, 3'b100, 10'h043, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{K0, 1'b0, 3'b000, 10'h043, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{KS, 1'b0, 3'b110, 10'h043, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{K0, 1'b0, 3'b000, 10'h043, 1'b1, 1'b1, 1'b0};
        // Dot after termination: reported but not stored
        tbl[11] = '{KD, 1'b0, 3'b100, 10'h043, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{K0, 1'b0, 3'b000, 10'h043, 1'b1, 1'b1, 1'b0};
        // Clear together with a Dash edge: event discarded, terminator kept
        tbl[13] = '{KA, 1'b1, 3'b101, 10'h3FF, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{K0, 1'b0, 3'b000, 10'h3FF, 1'b0, 1'b1, 1'b0};
        // Dot and Space together: Space wins, empty valid sequence
        tbl[15] = '{KD | KS, 1'b0, 3'b110, 10'h3FF, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{K0, 1'b0, 3'b000, 10'h3FF, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{K0, 1'b1, 3'b000, 10'h3FF, 1'b0, 1'b1, 1'b0};
        // Dot held five cycles: one event, one slot
        tbl[18] = '{KD, 1'b0, 3'b100, 10'h0FF, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{KD, 1'b0, 3'b000, 10'h0FF, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{KD, 1'b0, 3'b000, 10'h0FF, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{KD, 1'b0, 3'b000, 10'h0FF, 1'b0, 1'b1, 1'b0};
        tbl[22] = '{KD, 1'b0, 3'b000, 10'h0FF, 1'b0, 1'b1, 1'b0};
        tbl[23] = '{K0, 1'b0, 3'b000, 10'h0FF, 1'b0, 1'b1, 1'b0};
        tbl[24] = '{KE, 1'b0, 3'b111, 10'h0FF, 1'b1, 1'b0, 1'b0};
        tbl[25] = '{K0, 1'b0, 3'b000, 10'h0FF, 1'b1, 1'b0, 1'b0};
    end

    // ---------------- main sequence ----------------
    initial begin
        m_reset();
        #12;
        chk_all("reset", 3'b000, 10'h3FF, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            cyc(tbl[i].keys, tbl[i].clr);
            chk_all($sformatf("tbl%0d", i), tbl[i].sig, tbl[i].enc,
                    tbl[i].v, tbl[i].se, tbl[i].ov);
        end

        // Clear then Space only -> empty valid sequence
        cyc_m("clr", K0, 1'b1);
        cyc_m("sp_only", KS, 1'b0);
        chk("sp_only.enc", 32'(EncSeq), 32'h3FF);
        chk("sp_only.se", 32'(Space_EndSeqbar), 32'h1);
        cyc_m("idle", K0, 1'b0);

        // Mid-sequence asynchronous reset
        cyc_m("pre_rst", K0, 1'b1);
        cyc_m("pre_rst_d", KD, 1'b0);
        cyc_m("pre_rst_0", K0, 1'b0);
        cyc_m("pre_rst_a", KA, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        m_reset();
        chk_all("async_rst", 3'b000, 10'h3FF, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        {EndSeq, Space, Dash, Dot} = 4'b0000;
        Reset_n = 1'b1;
        cyc_m("r_d1", KD, 1'b0); cyc_m("r_01", K0, 1'b0);
        cyc_m("r_a",  KA, 1'b0); cyc_m("r_02", K0, 1'b0);
        cyc_m("r_d2", KD, 1'b0); cyc_m("r_03", K0, 1'b0);
        cyc_m("r_d3", KD, 1'b0); cyc_m("r_04", K0, 1'b0);
        cyc_m("r_e",  KE, 1'b0);
        chk_all("after_rst_seq", 3'b111, 10'h043, 1'b1, 1'b0, 1'b0);
        cyc_m("r_05", K0, 1'b0);

        // Six dashes overflow the five slots
        cyc_m("ov_clr", K0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc_m($sformatf("ov_a%0d", i), KA, 1'b0);
            cyc_m($sformatf("ov_z%0d", i), K0, 1'b0);
        end
        cyc_m("ov_e", KE, 1'b0);
        chk_all("overflow", 3'b111, 10'h155, 1'b1, 1'b0, 1'b1);
        cyc_m("ov_clr2", K0, 1'b1);
        chk("ov_cleared", 32'(Overflow), 32'h0);

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] k;
            logic       c;
            k[0] = ($urandom_range(0, 2) == 0);
            k[1] = ($urandom_range(0, 2) == 0);
            k[2] = ($urandom_range(0, 11) == 0);
            k[3] = ($urandom_range(0, 11) == 0);
            c    = ($urandom_range(0, 13) == 0);
            cyc_m($sformatf("rnd%0d", i), k, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_morse_sequence_builder
`default_nettype wire

// File: doc/morse_sequence_builder.md
Name: morse_sequence_builder

Overview:
Converts Morse key-event pulses (Dot, Dash, Space, EndSeq) into an encoded symbol sequence of up to MAX_SYMBOLS elements. It is packed into a fixed-width register for the downstream letter decoder.
- Front end: edge-detects the four inputs and priority-encodes them into a 3-bit event code.
- Back end: accumulates symbols and records how the sequence was terminated.

Parameters:
MAX_SYMBOLS, 5, number of symbol slots; EncSeq width = 2*MAX_SYMBOLS.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Reset_n  input  1  asynchronous active-low reset.
Dot  input  1  dot key (level; the event is its rising edge).
Dash  input  1  dash key.
Space  input  1  terminate sequence: letter followed by a word space.
EndSeq  input  1  terminate sequence: end of letter, no space.
Clear  input  1  synchronous clear of the sequence.
Signals  output  3  registered event code (see Behaviour).
EncSeq  output  2*MAX_SYMBOLS  packed symbol slots; slot 0 in the MSBs.
Space_EndSeqbar  output  1  terminator kind: 1 = Space, 0 = EndSeq.
SeqValid  output  1  high once the sequence has been terminated, until Clear or reset.
Overflow  output  1  sticky; a Dot/Dash arrived while all slots were full.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - Signals=000.
  - All EncSeq slots=2'b11 (empty), so EncSeq = all ones.
  - Space_EndSeqbar=0, SeqValid=0, Overflow=0, internal count=0.
  - Edge-detect history registers=0.
- Edge detect: each input is sampled once per clock. An event is a 0->1 transition between consecutive samples. A held level produces exactly one event.
- Priority when several events occur in the same cycle: EndSeq > Space > Dash > Dot. Only the winner is processed.
- Signals event codes, registered one cycle after the edge:
  - 000 = none
  - 100 = dot
  - 101 = dash
  - 110 = space
  - 111 = endseq
  - Signals returns to 000 on the following cycle unless a new event occurs.
- Symbol codes: dot=00, dash=01, empty=11. Code 10 is reserved and never written.
- Dot or Dash event, when SeqValid=0 and count<MAX_SYMBOLS:
  - Write the symbol into slot[count]; slot k occupies EncSeq[2*(MAX_SYMBOLS-k)-1 -: 2].
  - count increments.
  - EncSeq updates on the same edge as Signals, i.e. one cycle after the input edge.
- Dot or Dash event when count==MAX_SYMBOLS: EncSeq is unchanged and Overflow is set.
- Space or EndSeq event, when SeqValid=0:
  - SeqValid set to 1.
  - Space_EndSeqbar = 1 for Space, 0 for EndSeq.
  - EncSeq is frozen.
  - Valid with count=0 (an empty sequence, all slots 11).
- Any Dot/Dash/Space/EndSeq event while SeqValid=1 is ignored, except that Signals still reports it.
- Clear=1 at a clock edge:
  - All slots become 11, count=0, SeqValid=0, Overflow=0.
  - Space_EndSeqbar holds its last value.
  - Clear has priority over an event in the same cycle, and that event is discarded.
  - Signals is unaffected by Clear.
- Asserting Reset_n mid-sequence discards all state immediately.

Optional Feature:
MORSE_SYMCOUNT_EN
- Defined: adds output SymCount, width $clog2(MAX_SYMBOLS+1), equal to the internal count. It resets to 0 and clears with Clear.
- Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Package morse_pkg holds:
  - symbol codes SYM_DOT=2'b00, SYM_DASH=2'b01, SYM_EMPTY=2'b11;
  - event codes EV_NONE, EV_DOT, EV_DASH, EV_SPACE, EV_ENDSEQ as 3-bit constants.
- One sub-module, morse_event_encoder: edge detection, priority encoding and the registered Signals output. The top module contains the slot register, counter and flags.

Test Plan:
- Reset, then Clear, then edges Dot, Dash, Dot, Dot, then Space -> EncSeq=10'b00_01_00_00_11, SeqValid=1, Space_EndSeqbar=1, Overflow=0.
- Clear, then Space only -> EncSeq=10'h3FF, SeqValid=1, Space_EndSeqbar=1.
- Reset_n pulse, then Dot, Dash, Dot, Dot, EndSeq -> EncSeq=10'b00_01_00_00_11, Space_EndSeqbar=0, SeqValid=1.
- Six Dashes, then EndSeq -> EncSeq=10'b01_01_01_01_01, Overflow=1, SeqValid=1.
- Dot and Space rising in the same cycle -> Signals=110, no symbol stored. A Dot after termination leaves EncSeq unchanged while Signals pulses 100.
- Dot held high for 5 cycles -> exactly one slot written and Signals=100 for exactly one cycle. Clear coinciding with a Dash edge -> EncSeq=all ones, count=0.
